// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit width, flit type, transmitter states and
// the Hermes size-flit builder.
package noc_pkg;

  localparam int unsigned FLIT_WIDTH_DEF = 32;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StSendHdr,
    StSendSize,
    StSendPay
  } tx_state_e;

  // Size flit carries the payload flit count, zero-extended.
  function automatic flit_t make_size_flit(input int unsigned count);
    return flit_t'(count);
  endfunction

endpackage

// File: rtl/ni_flit_buf.sv
// Packet buffer for the NI transmitter: DEPTH x FLIT_WIDTH register array with
// one write port and a look-ahead combinational read port.
module ni_flit_buf
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_first,
  input  logic [FLIT_WIDTH-1:0] wr_data,
  output logic [AW-1:0]         wr_ptr,
  input  logic                  rd_restart,
  input  logic                  rd_adv,
  output logic [AW-1:0]         rd_ptr,
  output logic [FLIT_WIDTH-1:0] rd_data,
  output logic [FLIT_WIDTH-1:0] hdr_data
);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW-1:0]         rd_ptr_d;

  // The header always lands in slot 0, restarting the write pointer.
  assign wr_addr = wr_first ? '0 : wr_ptr_q;

  // Next read pointer; payload starts at slot 1, just after the header.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (rd_restart) begin
      rd_ptr_d = AW'(1);
    end else if (rd_adv) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Pointer registers, cleared on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_addr + AW'(1);
      end
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read at the next pointer so the registered data_i lines up with it.
  assign rd_data  = mem[rd_ptr_d];
  assign hdr_data = mem[0];
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;

endmodule

// File: rtl/ni_packet_tx.sv
// NI packet transmitter: store-and-forward of a host packet into a router
// local port, inserting the size flit and obeying credit flow control.
// Optional statistics counters are built when NI_PACKET_TX_STATS_EN is defined.
module ni_packet_tx
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [FLIT_WIDTH-1:0] host_data,
  input  logic                  host_last,
  output logic                  clock_rx,
  output logic                  rx,
  output logic [FLIT_WIDTH-1:0] data_i,
  input  logic                  credit_o,
  output logic                  err_trunc,
  output logic [15:0]           pkt_sent,
  output logic [31:0]           stall_cycles
);

  localparam int unsigned CW = $clog2(DEPTH);

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  accept, xfer;
  logic                  wr_en, wr_first, rd_restart, rd_adv;
  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [FLIT_WIDTH-1:0] rd_data, hdr_data, data_d;

  assign clock_rx = clock;

  ni_flit_buf #(
    .FLIT_WIDTH(FLIT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_first  (wr_first),
    .wr_data   (host_data),
    .wr_ptr    (wr_ptr),
    .rd_restart(rd_restart),
    .rd_adv    (rd_adv),
    .rd_ptr    (rd_ptr),
    .rd_data   (rd_data),
    .hdr_data  (hdr_data)
  );

  // Next state, buffer controls and truncation pulse.
  always_comb begin
    accept     = host_valid && host_ready;
    xfer       = rx && credit_o;
    state_d    = state_q;
    count_d    = count_q;
    wr_en      = 1'b0;
    wr_first   = 1'b0;
    rd_restart = 1'b0;
    rd_adv     = 1'b0;
    err_trunc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_first = 1'b1;
          count_d  = '0;
          state_d  = host_last ? StSendHdr : StFill;
        end
      end
      StFill: begin
        if (accept) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (host_last) begin
            state_d = StSendHdr;
          end else if (wr_ptr == CW'(DEPTH - 1)) begin
            // Buffer full without last: close the packet here.
            state_d   = StSendHdr;
            err_trunc = 1'b1;
          end
        end
      end
      StSendHdr: begin
        if (xfer) begin
          rd_restart = 1'b1;
          state_d    = StSendSize;
        end
      end
      StSendSize: begin
        if (xfer) begin
          state_d = (count_q != '0) ? StSendPay : StIdle;
        end
      end
      StSendPay: begin
        if (xfer) begin
          rd_adv = 1'b1;
          if (rd_ptr == count_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Flit to present next cycle; header bypasses the array when written now.
  always_comb begin
    data_d = '0;
    unique case (state_d)
      StSendHdr:  data_d = wr_first ? host_data : hdr_data;
      StSendSize: data_d = FLIT_WIDTH'(make_size_flit(32'(count_d)));
      StSendPay:  data_d = rd_data;
      default:    data_d = '0;
    endcase
  end

  // State and registered outputs; a stalled flit is recomputed unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      host_ready <= 1'b0;
      rx         <= 1'b0;
      data_i     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      host_ready <= (state_d == StIdle) || (state_d == StFill);
      rx         <= (state_d == StSendHdr) || (state_d == StSendSize) || (state_d == StSendPay);
      data_i     <= data_d;
    end
  end

`ifdef NI_PACKET_TX_STATS_EN
  logic        last_xfer;
  logic [15:0] pkt_q;
  logic [31:0] stall_q;

  assign last_xfer = xfer && (((state_q == StSendSize) && (count_q == '0)) ||
                              ((state_q == StSendPay) && (rd_ptr == count_q)));

  // Packet counter wraps; stall counter saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      if (last_xfer) begin
        pkt_q <= pkt_q + 16'd1;
      end
      if (rx && !credit_o && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign pkt_sent     = pkt_q;
  assign stall_cycles = stall_q;
`else
  assign pkt_sent     = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ni_packet_tx.sv
// Directed bench for ni_packet_tx with a router-side log and a small model of
// the expected flit stream and statistics.
module tb_ni_packet_tx;

`ifdef NI_PACKET_TX_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [31:0] host_data = '0;
  logic        host_last = 1'b0;
  logic        clock_rx;
  logic        rx;
  logic [31:0] data_i;
  logic        credit_o = 1'b1;
  logic        err_trunc;
  logic [15:0] pkt_sent;
  logic [31:0] stall_cycles;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  int          log_base = 0;
  int          stall_m = 0;
  int          pkt_m = 0;
  int          cmode = 0;

  ni_packet_tx #(
    .FLIT_WIDTH(32),
    .DEPTH     (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_data   (host_data),
    .host_last   (host_last),
    .clock_rx    (clock_rx),
    .rx          (rx),
    .data_i      (data_i),
    .credit_o    (credit_o),
    .err_trunc   (err_trunc),
    .pkt_sent    (pkt_sent),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Router side: log every transfer, count stall cycles.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      stall_m = 0;
    end else begin
      if (rx && credit_o) log_q.push_back(data_i);
      if (rx && !credit_o) stall_m++;
    end
  end

  // Credit driver: 0 always 1, 1 random, 2 low for send cycles 2..4.
  initial begin
    int sc;
    sc = 0;
    forever begin
      @(posedge clock);
      #1;
      sc = rx ? sc + 1 : 0;
      case (cmode)
        1:       credit_o = 1'($urandom_range(0, 1));
        2:       credit_o = !(sc >= 2 && sc <= 4);
        default: credit_o = 1'b1;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_flit(input logic [31:0] d, input logic l, output logic tr);
    bit ok;
    ok = 1'b0;
    tr = 1'b0;
    host_valid = 1'b1;
    host_data  = d;
    host_last  = l;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (host_ready) begin
        ok = 1'b1;
        tr = err_trunc;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int n, input logic [31:0] p0);
    logic tr;
    push_flit(hdr, n == 0, tr);
    exp_q.push_back(hdr);
    exp_q.push_back(32'(n));
    for (int i = 0; i < n; i++) begin
      push_flit(p0 + 32'(i), i == n - 1, tr);
      exp_q.push_back(p0 + 32'(i));
    end
    pkt_m++;
  endtask

  task automatic wait_and_compare(input string tag);
    int k;
    k = 0;
    while (log_q.size() < log_base + exp_q.size() && k < 5000) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock);
    #1;
    check_eq({tag, "_count"}, 64'(log_q.size() - log_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      check_eq({tag, "_flit"}, 64'(log_q[log_base + i]), 64'(exp_q[i]));
    end
    check_eq({tag, "_rx_idle"}, 64'(rx), 64'd0);
    log_base = log_q.size();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] t2 [8];
    logic        tr;

    repeat (2) @(negedge clock);
    check_eq("rst_host_ready", 64'(host_ready), 64'd0);
    check_eq("rst_rx", 64'(rx), 64'd0);
    check_eq("rst_data_i", 64'(data_i), 64'd0);
    check_eq("rst_err_trunc", 64'(err_trunc), 64'd0);
    check_eq("rst_pkt_sent", 64'(pkt_sent), 64'd0);
    check_eq("rst_stall", 64'(stall_cycles), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("idle_host_ready", 64'(host_ready), 64'd1);

    // Basic packet, full credit.
    send_pkt(32'h11, 3, 32'hA1);
    check_eq("t1_rx_latency", 64'(rx), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("t1_rx", 64'(rx), 64'd1);
      check_eq("t1_data", 64'(data_i), 64'(exp_q[i]));
    end
    wait_and_compare("t1");
    check_eq("t1_host_ready", 64'(host_ready), 64'd1);
    check_eq("t1_pkt_sent", 64'(pkt_sent), Stats ? 64'd1 : 64'd0);

    // Same packet with a three-cycle credit stall on the size flit.
    cmode = 2;
    t2 = '{32'h11, 32'h3, 32'h3, 32'h3, 32'h3, 32'hA1, 32'hA2, 32'hA3};
    send_pkt(32'h11, 3, 32'hA1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_eq("t2_rx", 64'(rx), 64'd1);
      check_eq("t2_data", 64'(data_i), 64'(t2[i]));
    end
    wait_and_compare("t2");
    check_eq("t2_stall", 64'(stall_cycles), Stats ? 64'd3 : 64'd0);
    check_eq("t2_pkt_sent", 64'(pkt_sent), Stats ? 64'd2 : 64'd0);
    cmode = 0;

    // Header-only packet.
    send_pkt(32'h77, 0, 32'h0);
    @(negedge clock);
    check_eq("t3_hdr", 64'(data_i), 64'h77);
    @(negedge clock);
    check_eq("t3_size", 64'(data_i), 64'h0);
    check_eq("t3_size_rx", 64'(rx), 64'd1);
    @(negedge clock);
    check_eq("t3_rx_off", 64'(rx), 64'd0);
    check_eq("t3_host_ready", 64'(host_ready), 64'd1);
    wait_and_compare("t3");

    // Truncation: 16 flits without last, then 4 more closing a new packet.
    for (int i = 0; i < 16; i++) begin
      push_flit(32'h100 + 32'(i), 1'b0, tr);
      if (i == 14) check_eq("t4_no_trunc15", 64'(tr), 64'd0);
      if (i == 15) check_eq("t4_trunc16", 64'(tr), 64'd1);
    end
    check_eq("t4_ready_low", 64'(host_ready), 64'd0);
    for (int i = 16; i < 20; i++) begin
      push_flit(32'h100 + 32'(i), i == 19, tr);
    end
    exp_q.push_back(32'h100);
    exp_q.push_back(32'd15);
    for (int i = 1; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
    exp_q.push_back(32'h110);
    exp_q.push_back(32'd3);
    for (int i = 17; i < 20; i++) exp_q.push_back(32'h100 + 32'(i));
    pkt_m += 2;
    wait_and_compare("t4");
    check_eq("t4_pkt_sent", 64'(pkt_sent), Stats ? 64'd5 : 64'd0);

    // Reset during the payload, then a clean packet.
    send_pkt(32'h55, 4, 32'hB1);
    exp_q.delete();
    repeat (3) @(negedge clock);
    @(negedge clock);
    check_eq("t5_pay2", 64'(data_i), 64'hB2);
    #1 reset = 1'b0;
    #1;
    check_eq("t5_rx_async", 64'(rx), 64'd0);
    check_eq("t5_data_async", 64'(data_i), 64'd0);
    check_eq("t5_ready_async", 64'(host_ready), 64'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("t5_ready_after", 64'(host_ready), 64'd1);
    log_base = log_q.size();
    pkt_m = 0;
    send_pkt(32'h66, 2, 32'hC1);
    wait_and_compare("t5");
    check_eq("t5_pkt_sent", 64'(pkt_sent), Stats ? 64'd1 : 64'd0);

    // Random credit, 100 random packets.
    cmode = 1;
    for (int p = 0; p < 100; p++) begin
      send_pkt($urandom, int'($urandom_range(0, 15)), $urandom);
    end
    wait_and_compare("t6");
    cmode = 0;
    check_eq("t6_pkt_sent", 64'(pkt_sent), Stats ? 64'(pkt_m) : 64'd0);
    check_eq("t6_stall", 64'(stall_cycles), Stats ? 64'(stall_m) : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
